v6_mig_app_master: RTL

V6_MIG_APP_MASTER -- requirements
Module: v6_mig_app_master

---
 rtl/v6_mig_app_master_if.sv | 59 +++++
 rtl/v6_mig_app_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/v6_mig_app_master_if.sv
// v6_mig_app_master_if
//   Bundles the client request/response channel and the MIG user-side
//   application channel of v6_mig_app_master.
//   master modport : the app master itself (drives app_* commands/write data,
//                    req_ready, rsp_*, rd_outstanding).
//   slave modport  : the environment (client + MIG controller).
//   Signals:
//     phy_init_done              MIG calibration complete
//     req_valid/req_ready        client request handshake
//     req_write/req_addr         request type and burst address
//     req_wdata/req_wmask        write burst (beat0 = low half), mask 1 = keep byte
//     rsp_valid/rsp_data         read-burst-complete strobe and data
//     rd_outstanding             outstanding read command count
//     app_addr/app_cmd/app_en/app_rdy                        MIG command channel
//     app_wdf_data/mask/wren/end, app_wdf_rdy                MIG write data channel
//     app_rd_data/app_rd_data_valid/app_rd_data_end          MIG read return channel
interface v6_mig_app_master_if #(
  parameter int ADDR_WIDTH    = 27,
  parameter int PAYLOAD_WIDTH = 64
) ();
  localparam int BW = 4 * PAYLOAD_WIDTH;

  logic                  phy_init_done;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2*BW-1:0]       req_wdata;
  logic [2*BW/8-1:0]     req_wmask;
  logic                  rsp_valid;
  logic [2*BW-1:0]       rsp_data;
  logic [3:0]            rd_outstanding;
  logic [ADDR_WIDTH-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [BW-1:0]         app_wdf_data;
  logic [BW/8-1:0]       app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;
  logic [BW-1:0]         app_rd_data;
  logic                  app_rd_data_valid;
  logic                  app_rd_data_end;

  modport master (
    input  phy_init_done, req_valid, req_write, req_addr, req_wdata, req_wmask,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    output req_ready, rsp_valid, rsp_data, rd_outstanding,
           app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output phy_init_done, req_valid, req_write, req_addr, req_wdata, req_wmask,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    input  req_ready, rsp_valid, rsp_data, rd_outstanding,
           app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/v6_mig_app_master.sv
// v6_mig_app_master
//   Turns single-word client requests (one BL8 burst = two app beats) into
//   Virtex-6 MIG user-interface commands. Writes push a command plus two
//   write-data beats; reads push a command and are tracked by an outstanding
//   counter. Read returns are reassembled into a full burst and reported with
//   a one-cycle rsp_valid strobe.
//   Ports:
//     tb_clk    user clock (MIG ui clock)
//     tb_rst_n  asynchronous active-low reset
//     bus       v6_mig_app_master_if.master (request/response + MIG app channel)
module v6_mig_app_master #(
  parameter int ADDR_WIDTH    = 27,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int MAX_RD        = 8
) (
  input  logic               tb_clk,
  input  logic               tb_rst_n,
  v6_mig_app_master_if.master bus
);
  localparam int         BW       = 4 * PAYLOAD_WIDTH;
  localparam int         MW       = BW / 8;
  localparam logic [3:0] MAX_RD_L = 4'(MAX_RD);
  localparam logic [2:0] CMD_WR   = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b001;

  typedef enum logic [1:0] {INIT, IDLE, WRITE, READ} state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  app_en_q, app_en_d;
  logic [2:0]            app_cmd_q, app_cmd_d;
  logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
  logic                  wren_q, wren_d;
  logic                  wend_q, wend_d;
  logic [BW-1:0]         wdf_data_q, wdf_data_d;
  logic [MW-1:0]         wdf_mask_q, wdf_mask_d;
  logic [BW-1:0]         whi_data_q, whi_data_d;
  logic [MW-1:0]         whi_mask_q, whi_mask_d;
  logic [BW-1:0]         rd_lo_q, rd_lo_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [2*BW-1:0]       rsp_data_q, rsp_data_d;
  logic [3:0]            rd_out_q, rd_out_d;

  logic req_ready_w, accept, cmd_hs, wdf_hs, rd_inc, rd_dec;

  // ready is a registered qualifier; phy_init_done only gates it so a
  // calibration drop never aborts work that is already in flight.
  assign req_ready_w = ready_q & bus.phy_init_done;
  assign accept      = bus.req_valid & req_ready_w;
  assign cmd_hs      = app_en_q & bus.app_rdy;
  assign wdf_hs      = wren_q & bus.app_wdf_rdy;
  assign rd_inc      = (state_q == READ) & cmd_hs;
  // An end beat with nothing outstanding is stray and is dropped.
  assign rd_dec      = bus.app_rd_data_valid & bus.app_rd_data_end & (rd_out_q != 4'd0);

  always_comb begin
    state_d     = state_q;
    app_en_d    = app_en_q;
    app_cmd_d   = app_cmd_q;
    app_addr_d  = app_addr_q;
    wren_d      = wren_q;
    wend_d      = wend_q;
    wdf_data_d  = wdf_data_q;
    wdf_mask_d  = wdf_mask_q;
    whi_data_d  = whi_data_q;
    whi_mask_d  = whi_mask_q;
    rd_lo_d     = rd_lo_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rd_out_d    = rd_out_q + {3'b000, rd_inc} - {3'b000, rd_dec};

    unique case (state_q)
      INIT: begin
        if (bus.phy_init_done) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          app_en_d   = 1'b1;
          app_addr_d = {bus.req_addr[ADDR_WIDTH-1:3], 3'b000};
          if (bus.req_write) begin
            state_d    = WRITE;
            app_cmd_d  = CMD_WR;
            wren_d     = 1'b1;
            wend_d     = 1'b0;
            wdf_data_d = bus.req_wdata[BW-1:0];
            wdf_mask_d = bus.req_wmask[MW-1:0];
            whi_data_d = bus.req_wdata[2*BW-1:BW];
            whi_mask_d = bus.req_wmask[2*MW-1:MW];
          end else begin
            state_d   = READ;
            app_cmd_d = CMD_RD;
          end
        end
      end
      WRITE: begin
        if (cmd_hs) app_en_d = 1'b0;
        if (wdf_hs) begin
          if (!wend_q) begin
            wdf_data_d = whi_data_q;
            wdf_mask_d = whi_mask_q;
            wend_d     = 1'b1;
          end else begin
            wren_d = 1'b0;
            wend_d = 1'b0;
          end
        end
        // Command and data channels finish independently; leave once both
        // are done (either already, or being accepted on this edge).
        if ((!app_en_q || bus.app_rdy) && (!wren_q || (wend_q && bus.app_wdf_rdy)))
          state_d = IDLE;
      end
      READ: begin
        if (cmd_hs) begin
          app_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = INIT;
    endcase

    // Read return is independent of the command FSM state.
    if (bus.app_rd_data_valid) begin
      if (!bus.app_rd_data_end) begin
        rd_lo_d = bus.app_rd_data;
      end else if (rd_out_q != 4'd0) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = {bus.app_rd_data, rd_lo_q};
      end
    end

    // Ready only after a full IDLE cycle, which also keeps the first ready
    // two cycles after reset release.
    ready_d = (state_q == IDLE) && (state_d == IDLE) && bus.phy_init_done &&
              (rd_out_d < MAX_RD_L);
  end

  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      state_q     <= INIT;
      ready_q     <= 1'b0;
      app_en_q    <= 1'b0;
      app_cmd_q   <= 3'b000;
      app_addr_q  <= '0;
      wren_q      <= 1'b0;
      wend_q      <= 1'b0;
      wdf_data_q  <= '0;
      wdf_mask_q  <= '0;
      whi_data_q  <= '0;
      whi_mask_q  <= '0;
      rd_lo_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rd_out_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      app_en_q    <= app_en_d;
      app_cmd_q   <= app_cmd_d;
      app_addr_q  <= app_addr_d;
      wren_q      <= wren_d;
      wend_q      <= wend_d;
      wdf_data_q  <= wdf_data_d;
      wdf_mask_q  <= wdf_mask_d;
      whi_data_q  <= whi_data_d;
      whi_mask_q  <= whi_mask_d;
      rd_lo_q     <= rd_lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rd_out_q    <= rd_out_d;
    end
  end

  assign bus.req_ready      = req_ready_w;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rd_outstanding = rd_out_q;
  assign bus.app_addr       = app_addr_q;
  assign bus.app_cmd        = app_cmd_q;
  assign bus.app_en         = app_en_q;
  assign bus.app_wdf_data   = wdf_data_q;
  assign bus.app_wdf_mask   = wdf_mask_q;
  assign bus.app_wdf_wren   = wren_q;
  assign bus.app_wdf_end    = wend_q;
endmodule
